// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : muldiv_pkg
// Brief  : Shared op encodings, FSM states and negate helper for muldiv_unit.
// Rev    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_MULHU  = 3'b011;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_DIVU   = 3'b101;
    localparam logic [2:0] c_OP_REM    = 3'b110;
    localparam logic [2:0] c_OP_REMU   = 3'b111;

    // Negate width; callers keep the low WIDTH or 2*WIDTH bits (WIDTH < 128).
    localparam int c_NEG_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [c_NEG_W-1:0] twos_neg(input logic [c_NEG_W-1:0] x);
        return ~x + {{(c_NEG_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module : muldiv_step
// Brief  : One iteration of the shared datapath: shift-add multiply or
//          restoring shift-subtract divide over the {hi, lo} accumulator.
// Rev    : 1.0  initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi_next,
    output logic [WIDTH-1:0] o_lo_next
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    always_comb begin
        w_sum   = {1'b0, i_hi} + {1'b0, i_opnd & {WIDTH{i_lo[0]}}};
        w_shift = {i_hi, i_lo[WIDTH-1]};
        w_fits  = w_shift >= {1'b0, i_opnd};
        // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
        w_diff  = w_shift[WIDTH-1:0] - i_opnd;
        if (i_is_div) begin
            o_hi_next = w_fits ? w_diff : w_shift[WIDTH-1:0];
            o_lo_next = {i_lo[WIDTH-2:0], w_fits};
        end else begin
            o_hi_next = w_sum[WIDTH:1];
            o_lo_next = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Rev    : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_op;
    logic             r_neg;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [c_NEG_W-1:0] w_neg_a;
    logic [c_NEG_W-1:0] w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_bzero;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;
    logic [WIDTH-1:0]   w_hi_next;
    logic [WIDTH-1:0]   w_lo_next;
    logic [2*WIDTH-1:0] w_fix_in;
    logic [c_NEG_W-1:0] w_fix_neg;
    logic [2*WIDTH-1:0] w_fixed;
    logic [WIDTH-1:0]   w_final;
    logic               w_unused_bits;

    assign w_accept = (r_state == IDLE) & in_valid & ~kill;

    // Operand sign/magnitude extraction at accept time
    assign w_sign_a = a[WIDTH-1] & ((op == c_OP_MULH) | (op == c_OP_MULHSU) |
                                    (op == c_OP_DIV)  | (op == c_OP_REM));
    assign w_sign_b = b[WIDTH-1] & ((op == c_OP_MULH) | (op == c_OP_DIV) | (op == c_OP_REM));
    assign w_neg_a  = twos_neg(c_NEG_W'(a));
    assign w_neg_b  = twos_neg(c_NEG_W'(b));
    assign w_mag_a  = w_sign_a ? w_neg_a[WIDTH-1:0] : a;
    assign w_mag_b  = w_sign_b ? w_neg_b[WIDTH-1:0] : b;

    assign w_bzero       = ~|b;
    assign w_ovf         = ((op == c_OP_DIV) | (op == c_OP_REM)) & (a == c_MIN) & (&b);
    assign w_special     = op[2] & (w_bzero | w_ovf);
    assign w_special_res = w_bzero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div  (r_op[2]),
        .i_hi      (r_hi),
        .i_lo      (r_lo),
        .i_opnd    (r_opnd),
        .o_hi_next (w_hi_next),
        .o_lo_next (w_lo_next)
    );

    // The last iteration and sign correction share the final CALC edge.
    assign w_fix_in  = r_op[2] ? {{WIDTH{1'b0}}, (r_op[1] ? w_hi_next : w_lo_next)}
                               : {w_hi_next, w_lo_next};
    assign w_fix_neg = twos_neg(c_NEG_W'(w_fix_in));
    assign w_fixed   = r_neg ? w_fix_neg[2*WIDTH-1:0] : w_fix_in;
    assign w_final   = (~r_op[2] & (r_op[1:0] != 2'b00)) ? w_fixed[2*WIDTH-1:WIDTH]
                                                         : w_fixed[WIDTH-1:0];

    assign w_unused_bits = ^{w_neg_a[c_NEG_W-1:WIDTH], w_neg_b[c_NEG_W-1:WIDTH],
                             w_fix_neg[c_NEG_W-1:2*WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = w_special ? DONE : CALC;
            CALC: begin
                if (kill) begin
                    w_state_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE:    if (kill | out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_op   <= op;
            r_neg  <= (op == c_OP_REM) ? w_sign_a : (w_sign_a ^ w_sign_b);
            r_hi   <= '0;
            r_lo   <= op[2] ? w_mag_a : w_mag_b;
            r_opnd <= op[2] ? w_mag_b : w_mag_a;
            r_cnt  <= CNT_W'(WIDTH - 1);
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == CALC) begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
                r_result <= w_final;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_muldiv_unit
// Brief  : Directed self-checking bench for muldiv_unit at WIDTH=32.
// Rev    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             kill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation; edges counts the accepting edge as edge 1.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int edges);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; op = ~o; a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5;
        edges = 1;
        while (!out_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        res = result;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] r;
        int e;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, e);
        checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_val got=%h exp=ffffffeb", r); end
        checks++; if (e !== 33) begin failures++; $display("FAIL mul_lat got=%0d exp=33", e); end
        do_op(3'b001, 32'd7, 32'hFFFF_FFFD, r, e);
        checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulh_val got=%h exp=ffffffff", r); end
        checks++; if (e !== 33) begin failures++; $display("FAIL mulh_lat got=%0d exp=33", e); end
    endtask

    task automatic test_mul_high();
        logic [31:0] r;
        int e;
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, r, e);
        checks++; if (r !== 32'h4000_0000) begin failures++; $display("FAIL mulh_min got=%h exp=40000000", r); end
        do_op(3'b011, 32'h8000_0000, 32'h8000_0000, r, e);
        checks++; if (r !== 32'h4000_0000) begin failures++; $display("FAIL mulhu_min got=%h exp=40000000", r); end
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, e);
        checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu got=%h exp=ffffffff", r); end
    endtask

    task automatic test_div();
        logic [31:0] r;
        int e;
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, e);
        checks++; if (r !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg got=%h exp=fffffffd", r); end
        checks++; if (e !== 33) begin failures++; $display("FAIL div_lat got=%0d exp=33", e); end
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, e);
        checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_neg got=%h exp=ffffffff", r); end
        do_op(3'b101, 32'd100, 32'd7, r, e);
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL divu got=%h exp=0000000e", r); end
        do_op(3'b111, 32'd100, 32'd7, r, e);
        checks++; if (r !== 32'd2) begin failures++; $display("FAIL remu got=%h exp=00000002", r); end
    endtask

    task automatic test_special();
        logic [31:0] r;
        int e;
        do_op(3'b101, 32'd5, 32'd0, r, e);
        checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_by0 got=%h exp=ffffffff", r); end
        checks++; if (e !== 1) begin failures++; $display("FAIL divu_by0_lat got=%0d exp=1", e); end
        do_op(3'b111, 32'd5, 32'd0, r, e);
        checks++; if (r !== 32'd5) begin failures++; $display("FAIL remu_by0 got=%h exp=00000005", r); end
        checks++; if (e !== 1) begin failures++; $display("FAIL remu_by0_lat got=%0d exp=1", e); end
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, e);
        checks++; if (r !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf got=%h exp=80000000", r); end
        checks++; if (e !== 1) begin failures++; $display("FAIL div_ovf_lat got=%0d exp=1", e); end
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, e);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL rem_ovf got=%h exp=00000000", r); end
        checks++; if (e !== 1) begin failures++; $display("FAIL rem_ovf_lat got=%0d exp=1", e); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        op = 3'b101; a = 32'd100; b = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (result !== 32'd14) begin failures++; $display("FAIL bp_result_c%0d got=%h exp=0000000e", i, result); end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++; $display("FAIL bp_hold_c%0d got in_ready=%b out_valid=%b exp 0/1", i, in_ready, out_valid);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_consume_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_idle got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_kill();
        int seen;
        @(negedge clk);
        op = 3'b000; a = 32'd9; b = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL kill_calc got busy=%b in_ready=%b out_valid=%b exp 0/1/0", busy, in_ready, out_valid);
        end
        @(negedge clk);
        kill = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL kill_no_result got=%0d exp=0", seen); end
        out_ready = 1'b0;
    endtask

    task automatic test_kill_idle();
        @(negedge clk);
        op = 3'b101; a = 32'd5; b = 32'd0; in_valid = 1'b1; kill = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL kill_idle got busy=%b out_valid=%b exp 0/0", busy, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0; kill = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        op = 3'b011; a = 32'h8000_0000; b = 32'h8000_0000; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!out_valid && n < 100);
        checks++; if (n !== WIDTH + 2) begin failures++; $display("FAIL b2b_period got=%0d exp=%0d", n, WIDTH + 2); end
        checks++; if (result !== 32'h4000_0000) begin failures++; $display("FAIL b2b_result got=%h exp=40000000", result); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int e;
        @(negedge clk);
        op = 3'b000; a = 32'd11; b = 32'd13; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_ctrl got busy=%b in_ready=%b out_valid=%b exp 0/1/0", busy, in_ready, out_valid);
        end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL rst_mid_result got=%h exp=0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'b000, 32'd3, 32'd4, r, e);
        checks++; if (r !== 32'd12) begin failures++; $display("FAIL rst_mid_mul got=%h exp=0000000c", r); end
        checks++; if (e !== 33) begin failures++; $display("FAIL rst_mid_lat got=%0d exp=33", e); end
    endtask

    initial begin
        in_valid = 1'b0; op = 3'b000; a = '0; b = '0; kill = 1'b0; out_ready = 1'b0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_backpressure();
        test_kill();
        test_kill_idle();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit implementing the full RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a parametrised width. It sits beside the combinational ALU in the execute stage. It completes the M-extension operations that the ALU only stubs, including real division and remainder. Operands enter and results leave through valid/ready handshakes, so the pipeline stalls on busy.

## Interface
- `WIDTH`, 32: operand/result width in bits, any even value ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low; one clock domain only.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `op`  in  3  RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  WIDTH  rs1 operand (dividend/multiplicand).
- `b`  in  WIDTH  rs2 operand (divisor/multiplier).
- `kill`  in  1  synchronous abort of the in-flight operation.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  WIDTH  registered result.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Handshake: accept on the edge where `in_valid & in_ready`. Operands and `op` are captured, so inputs may change afterwards. A result is consumed on the edge where `out_valid & out_ready`. `result` and `out_valid` hold stable until consumed.
- States:
  - IDLE: waits for a request.
    - Accept of a special case → DONE.
    - Other accept → CALC.
  - CALC: iterates; counter counts WIDTH−1 down to 0.
    - Counter == 0 → DONE.
  - DONE: presents the result.
    - Consumed → IDLE.
- Sign handling at accept:
  - MULH, DIV, REM: both operands are signed.
  - MULHSU: `a` is signed and `b` is unsigned.
  - All other ops: unsigned.
  - Signed operands are converted to magnitudes.
  - Result sign flags are recorded:
    - MUL/MULH*: sign = sign_a XOR sign_b.
    - DIV: quotient sign = sign_a XOR sign_b.
    - REM: remainder takes sign_a.
- Multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per CALC cycle. MUL returns the low WIDTH bits. MULH/MULHSU/MULHU return the high WIDTH bits after two's-complement correction of the full 2·WIDTH product.
- Divide: restoring shift-subtract, one quotient bit per CALC cycle. After sign correction, DIV/DIVU return the quotient and REM/REMU return the remainder.
- Special cases, resolved at accept with no CALC phase:
  - b == 0:
    - DIV/DIVU return all ones.
    - REM/REMU return `a`.
  - Signed overflow, DIV/REM with a == 1 followed by zeros (most negative value) and b == all ones:
    - DIV returns `a`.
    - REM returns 0.
  - MUL with a == 0 or b == 0 is not a special case; it takes full latency.
- `kill`:
  - In CALC or DONE, the next state is IDLE and `out_valid` drops at that edge. No result is produced.
  - In IDLE, `kill` has priority over a simultaneous accept: nothing is accepted.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; the operation is lost.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0. Internal registers and counter are also cleared.
- Normal latency: `out_valid` rises at the (WIDTH+1)-th edge after the accepting edge, i.e. 33 edges for WIDTH=32. The final CALC edge performs sign correction and loads `result`.
- Special-case latency: `out_valid` rises at the first edge after acceptance.
- Throughput:
  - Best case, one operation every WIDTH+2 cycles.
  - `in_ready` is low in the cycle of consumption; IDLE is re-entered on the next edge.
- Backpressure: DONE holds indefinitely while `out_ready`=0.
- `in_ready`, `busy` and `out_valid` are decoded directly from state registers, with no combinational path from inputs.

## Structure
- Package `muldiv_pkg`:
  - `op` encoding constants (MUL … REMU).
  - State enum (IDLE, CALC, DONE).
  - Helper function for two's-complement negate at WIDTH and at 2·WIDTH.
- Sub-module `muldiv_step`: one combinational iteration of the shared datapath (conditional add for multiply, trial subtract for divide), selected by a multiply/divide flag. The top level holds the FSM, counter, operand/accumulator registers and sign correction.

## Test plan
- Signed multiply, WIDTH=32: `a`=7, `b`=0xFFFFFFFD.
  - MUL → 0xFFFFFFEB.
  - MULH → 0xFFFFFFFF.
  - Both arrive 33 edges after accept.
- High-half variants: 0x80000000 × 0x80000000.
  - MULH → 0x40000000.
  - MULHU → 0x40000000.
  - MULHSU with `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: `a`=0xFFFFFFF9 (−7), `b`=2.
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU of 100/7 → 14; REMU → 2.
- Special cases, each with `out_valid` one edge after accept:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure and abort:
  - Hold `out_ready`=0 for 10 cycles: `result` stays stable and `in_ready`=0; consumption is followed by IDLE one edge later.
  - Assert `kill` at CALC cycle 5: IDLE on the next edge and no `out_valid`.
  - `kill` together with `in_valid` in IDLE: no accept.
- Reset mid-operation: deassert `rst_n` asynchronously (between clock edges) during CALC. Outputs go to reset values immediately. A fresh MUL 3×4 issued after release → 12.
